scrambler_80211: RTL and testbench

- 802.11b (DSSS) self-synchronizing scrambler and descrambler pair, polynomial G(z) = z^-7 + z^-4 + 1, bit-serial.
- Scrambler path whitens the PHY transmit bitstream. The independent descrambler path recovers it on receive or loopback.
- Sits between the MAC bit serializer (LSB-first bytes) and the modulator.
- Both 7-bit shift-register states are exported for debug.

---
 rtl/scrambler_80211_if.sv | 36 +++
 rtl/scrambler_80211.sv | 94 +++++++++
 tb/tb_scrambler_80211.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scrambler_80211_if.sv
// Bit-stream bundle between the PHY test harness (master) and the 802.11b
// scrambler/descrambler pair (slave). Clock and reset stay outside.
// Optional build macro: SCRAMBLER_STATE_LOAD_EN adds load / load_value.
interface scrambler_80211_if;
  logic       enable;
  logic       bit_in;
  logic       bit_out;
  logic [6:0] state_out;
  logic       scr_in;
  logic       debit_out;
  logic [6:0] destate_out;
`ifdef SCRAMBLER_STATE_LOAD_EN
  logic       load;
  logic [6:0] load_value;

  modport master (
    output enable, bit_in, scr_in, load, load_value,
    input  bit_out, state_out, debit_out, destate_out
  );

  modport slave (
    input  enable, bit_in, scr_in, load, load_value,
    output bit_out, state_out, debit_out, destate_out
  );
`else
  modport master (
    output enable, bit_in, scr_in,
    input  bit_out, state_out, debit_out, destate_out
  );

  modport slave (
    input  enable, bit_in, scr_in,
    output bit_out, state_out, debit_out, destate_out
  );
`endif
endinterface

// File: rtl/scrambler_80211.sv
// 802.11b DSSS self-synchronizing scrambler + descrambler, G(z) = z^-7 + z^-4 + 1.
// Bit-serial, one bit per enabled clock on each path; both paths run
// concurrently and share only clock, reset and enable.
// Register indexing: [0] is the newest bit, [3] is 4 cycles old, [6] is 7 old.
// Optional build macro: SCRAMBLER_STATE_LOAD_EN (adds a state load that
// writes both shift registers, priority below reset and above enable).
module scrambler_80211 #(
  parameter logic [6:0] SEED   = 7'b1101100,
  parameter logic [6:0] DESEED = 7'b1101100
) (
  input  logic              clock,
  input  logic              reset,
  scrambler_80211_if.slave  bus
);

  logic [6:0] scrState_q;
  logic [6:0] scrState_d;
  logic       scrBit_q;
  logic       scrBit_d;
  logic [6:0] descState_q;
  logic [6:0] descState_d;
  logic       descBit_q;
  logic       descBit_d;
  logic       scrFeedback;
  logic       descFeedback;

  // Feedback taps: scrambler folds its own output history, descrambler folds received history
  always_comb begin
    scrFeedback  = bus.bit_in ^ scrState_q[3] ^ scrState_q[6];
    descFeedback = bus.scr_in ^ descState_q[3] ^ descState_q[6];
  end

  // Scrambler next state: shift in the scrambled bit so the sequence is self-synchronizing
  always_comb begin
    scrState_d = scrState_q;
    scrBit_d   = scrBit_q;
`ifdef SCRAMBLER_STATE_LOAD_EN
    if (bus.load) begin
      scrState_d = bus.load_value;
    end else if (bus.enable) begin
      scrState_d = {scrState_q[5:0], scrFeedback};
      scrBit_d   = scrFeedback;
    end
`else
    if (bus.enable) begin
      scrState_d = {scrState_q[5:0], scrFeedback};
      scrBit_d   = scrFeedback;
    end
`endif
  end

  // Descrambler next state: shift in the received bit (not the recovered one)
  always_comb begin
    descState_d = descState_q;
    descBit_d   = descBit_q;
`ifdef SCRAMBLER_STATE_LOAD_EN
    if (bus.load) begin
      descState_d = bus.load_value;
    end else if (bus.enable) begin
      descState_d = {descState_q[5:0], bus.scr_in};
      descBit_d   = descFeedback;
    end
`else
    if (bus.enable) begin
      descState_d = {descState_q[5:0], bus.scr_in};
      descBit_d   = descFeedback;
    end
`endif
  end

  // State registers with synchronous active-low reset taking priority over everything
  always_ff @(posedge clock) begin
    if (!reset) begin
      scrState_q  <= SEED;
      scrBit_q    <= 1'b0;
      descState_q <= DESEED;
      descBit_q   <= 1'b0;
    end else begin
      scrState_q  <= scrState_d;
      scrBit_q    <= scrBit_d;
      descState_q <= descState_d;
      descBit_q   <= descBit_d;
    end
  end

  // Outputs are straight register copies, no added latency
  always_comb begin
    bus.bit_out     = scrBit_q;
    bus.state_out   = scrState_q;
    bus.debit_out   = descBit_q;
    bus.destate_out = descState_q;
  end

endmodule

// File: tb/tb_scrambler_80211.sv
// Self-checking bench for scrambler_80211. Three instances: default seeds
// (dutA, loopback selectable), zero seeds (dutZ, impulse response) and a
// zero descrambler seed with permanent loopback (dutM, seed mismatch).
// The reference model works on bit sequences: y[n] = x[n]^y[n-4]^y[n-7] and
// x[n] = r[n]^r[n-4]^r[n-7], with the seeds supplying the history before n=0.
// Optional build macro: SCRAMBLER_STATE_LOAD_EN enables test_load.
module tb_scrambler_80211;

  localparam logic [6:0] SEED_DEF = 7'b1101100;

  logic clock = 1'b0;
  logic reset;
  logic en;
  logic bitIn;
  logic scrDrive;
  logic loopA;

  always #5 clock = ~clock;

  scrambler_80211_if ifA ();
  scrambler_80211_if ifZ ();
  scrambler_80211_if ifM ();

  assign ifA.enable = en;
  assign ifA.bit_in = bitIn;
  assign ifA.scr_in = loopA ? ifA.bit_out : scrDrive;
  assign ifZ.enable = en;
  assign ifZ.bit_in = bitIn;
  assign ifZ.scr_in = scrDrive;
  assign ifM.enable = en;
  assign ifM.bit_in = bitIn;
  assign ifM.scr_in = ifM.bit_out;

`ifdef SCRAMBLER_STATE_LOAD_EN
  logic       loadEn;
  logic [6:0] loadVal;
  assign ifA.load       = loadEn;
  assign ifA.load_value = loadVal;
  assign ifZ.load       = loadEn;
  assign ifZ.load_value = loadVal;
  assign ifM.load       = loadEn;
  assign ifM.load_value = loadVal;
`endif

  scrambler_80211 dutA (.clock(clock), .reset(reset), .bus(ifA.slave));
  scrambler_80211 #(.SEED(7'b0000000), .DESEED(7'b0000000)) dutZ (.clock(clock), .reset(reset), .bus(ifZ.slave));
  scrambler_80211 #(.DESEED(7'b0000000)) dutM (.clock(clock), .reset(reset), .bus(ifM.slave));

  int total = 0;
  int bad   = 0;

  // Reference model: histories of transmitted and received bits, oldest first
  bit txHist[$];
  bit rxHist[$];
  bit expBit;
  bit expDebit;
  bit sentHist[$];

  function automatic void modelReset(logic [6:0] s, logic [6:0] d);
    txHist.delete();
    rxHist.delete();
    for (int k = 6; k >= 0; k--) begin
      txHist.push_back(s[k]);
      rxHist.push_back(d[k]);
    end
    expBit   = 1'b0;
    expDebit = 1'b0;
  endfunction

  function automatic void modelStep(bit x, bit r);
    bit y;
    y = x ^ txHist[txHist.size() - 4] ^ txHist[txHist.size() - 7];
    expDebit = r ^ rxHist[rxHist.size() - 4] ^ rxHist[rxHist.size() - 7];
    expBit = y;
    txHist.push_back(y);
    rxHist.push_back(r);
    void'(txHist.pop_front());
    void'(rxHist.pop_front());
  endfunction

  function automatic logic [6:0] histState(bit rx);
    logic [6:0] st;
    for (int k = 0; k < 7; k++)
      st[k] = rx ? rxHist[rxHist.size() - 1 - k] : txHist[txHist.size() - 1 - k];
    return st;
  endfunction

  function automatic logic [15:0] expected();
    return {expBit, expDebit, histState(1'b0), histState(1'b1)};
  endfunction

  function automatic logic [15:0] observe(int sel);
    case (sel)
      0:       return {ifA.bit_out, ifA.debit_out, ifA.state_out, ifA.destate_out};
      1:       return {ifZ.bit_out, ifZ.debit_out, ifZ.state_out, ifZ.destate_out};
      default: return {ifM.bit_out, ifM.debit_out, ifM.state_out, ifM.destate_out};
    endcase
  endfunction

  // Drive one cycle and advance the model; loopback feeds the previous bit_out
  task automatic applyStimulus(int sel, bit x, bit enable_);
    bit rIn;
    rIn = ((sel == 0 && loopA) || sel == 2) ? expBit : scrDrive;
    bitIn = x;
    en    = enable_;
    @(posedge clock);
    #1;
    if (enable_) begin
      modelStep(x, rIn);
      sentHist.push_back(x);
    end
  endtask

  task automatic resetAll();
    reset = 1'b0;
    en    = 1'b1;
    bitIn = 1'($urandom);
    @(posedge clock);
    #1;
    reset = 1'b1;
    sentHist.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en    = 1'b1;
    bitIn = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (observe(0) !== {1'b0, 1'b0, SEED_DEF, SEED_DEF}) begin
      bad++;
      $display("[TB] FAIL reset_default got=%b expected=%b", observe(0), {1'b0, 1'b0, SEED_DEF, SEED_DEF});
    end
    total++;
    if (observe(2) !== {1'b0, 1'b0, SEED_DEF, 7'b0000000}) begin
      bad++;
      $display("[TB] FAIL reset_deseed got=%b expected=%b", observe(2), {1'b0, 1'b0, SEED_DEF, 7'b0000000});
    end
    reset = 1'b1;
  endtask

  task automatic test_impulse();
    bit impulse [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    resetAll();
    modelReset(7'b0000000, 7'b0000000);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, (i == 0), 1'b1);
      total++;
      if (ifZ.bit_out !== impulse[i]) begin
        bad++;
        $display("[TB] FAIL impulse bit %0d got=%b expected=%b", i, ifZ.bit_out, impulse[i]);
      end
      if (i == 0) begin
        total++;
        if (ifZ.state_out !== 7'b0000001) begin
          bad++;
          $display("[TB] FAIL impulse_state got=%b expected=0000001", ifZ.state_out);
        end
      end
      total++;
      if (observe(1) !== expected()) begin
        bad++;
        $display("[TB] FAIL impulse_model step %0d got=%b expected=%b", i, observe(1), expected());
      end
    end
  endtask

  task automatic test_enable_hold();
    resetAll();
    modelReset(SEED_DEF, SEED_DEF);
    loopA = 1'b1;
    for (int i = 0; i < 45; i++) begin
      // cycles 20..24 have enable low with random data on bit_in
      applyStimulus(0, 1'($urandom), !(i >= 20 && i < 25));
      total++;
      if (observe(0) !== expected()) begin
        bad++;
        $display("[TB] FAIL enable_hold step %0d got=%b expected=%b", i, observe(0), expected());
      end
    end
  endtask

  task automatic test_loopback_beacon();
    logic [7:0] b;
    resetAll();
    modelReset(SEED_DEF, SEED_DEF);
    loopA = 1'b1;
    for (int n = 0; n < 128; n++) begin
      b = 8'($urandom);
      for (int k = 0; k < 8; k++) begin
        applyStimulus(0, b[k], 1'b1);
        total++;
        if (observe(0) !== expected()) begin
          bad++;
          $display("[TB] FAIL loopback_model bit %0d got=%b expected=%b", sentHist.size(), observe(0), expected());
        end
        // The first received bit is bit_out's reset zero, so recovery locks once 7 real bits are in
        if (sentHist.size() >= 9) begin
          total++;
          if (ifA.debit_out !== sentHist[sentHist.size() - 2]) begin
            bad++;
            $display("[TB] FAIL loopback_delay2 bit %0d got=%b expected=%b", sentHist.size() - 2, ifA.debit_out, sentHist[sentHist.size() - 2]);
          end
        end
      end
    end
  endtask

  task automatic test_seed_mismatch();
    resetAll();
    modelReset(SEED_DEF, 7'b0000000);
    for (int n = 0; n < 150; n++) begin
      applyStimulus(2, 1'($urandom), 1'b1);
      total++;
      if (observe(2) !== expected()) begin
        bad++;
        $display("[TB] FAIL mismatch_model bit %0d got=%b expected=%b", n, observe(2), expected());
      end
      if (sentHist.size() >= 9) begin
        total++;
        if (ifM.debit_out !== sentHist[sentHist.size() - 2]) begin
          bad++;
          $display("[TB] FAIL mismatch_sync bit %0d got=%b expected=%b", sentHist.size() - 2, ifM.debit_out, sentHist[sentHist.size() - 2]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    bit pattern [16];
    bit firstRun [16];
    for (int i = 0; i < 16; i++) pattern[i] = 1'($urandom);
    resetAll();
    modelReset(SEED_DEF, SEED_DEF);
    loopA = 1'b1;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(0, (i < 16) ? pattern[i] : 1'($urandom), 1'b1);
      if (i < 16) firstRun[i] = expBit;
      total++;
      if (observe(0) !== expected()) begin
        bad++;
        $display("[TB] FAIL midstream_pre step %0d got=%b expected=%b", i, observe(0), expected());
      end
    end
    reset = 1'b0;
    en    = 1'b1;
    bitIn = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if (observe(0) !== {1'b0, 1'b0, SEED_DEF, SEED_DEF}) begin
      bad++;
      $display("[TB] FAIL midstream_reset got=%b expected=%b", observe(0), {1'b0, 1'b0, SEED_DEF, SEED_DEF});
    end
    reset = 1'b1;
    modelReset(SEED_DEF, SEED_DEF);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, pattern[i], 1'b1);
      total++;
      if (ifA.bit_out !== firstRun[i]) begin
        bad++;
        $display("[TB] FAIL midstream_restart step %0d got=%b expected=%b", i, ifA.bit_out, firstRun[i]);
      end
      total++;
      if (observe(0) !== expected()) begin
        bad++;
        $display("[TB] FAIL midstream_post step %0d got=%b expected=%b", i, observe(0), expected());
      end
    end
  endtask

`ifdef SCRAMBLER_STATE_LOAD_EN
  task automatic test_load();
    logic [6:0] v;
    bit heldBit;
    bit heldDebit;
    resetAll();
    modelReset(SEED_DEF, SEED_DEF);
    loopA = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 10; i++) applyStimulus(0, 1'($urandom), 1'b1);
      v       = 7'($urandom);
      loadEn  = 1'b1;
      loadVal = v;
      en      = 1'($urandom);
      bitIn   = 1'($urandom);
      @(posedge clock);
      #1;
      loadEn    = 1'b0;
      heldBit   = expBit;
      heldDebit = expDebit;
      modelReset(v, v);
      expBit    = heldBit;
      expDebit  = heldDebit;
      total++;
      if (observe(0) !== expected()) begin
        bad++;
        $display("[TB] FAIL load round %0d got=%b expected=%b", r, observe(0), expected());
      end
      for (int i = 0; i < 10; i++) begin
        applyStimulus(0, 1'($urandom), 1'b1);
        total++;
        if (observe(0) !== expected()) begin
          bad++;
          $display("[TB] FAIL load_after round %0d step %0d got=%b expected=%b", r, i, observe(0), expected());
        end
      end
    end
  endtask
`endif

  initial begin
    reset    = 1'b0;
    en       = 1'b0;
    bitIn    = 1'b0;
    scrDrive = 1'b0;
    loopA    = 1'b0;
`ifdef SCRAMBLER_STATE_LOAD_EN
    loadEn  = 1'b0;
    loadVal = 7'b0000000;
`endif
    test_reset();
    test_impulse();
    test_enable_hold();
    test_loopback_beacon();
    test_seed_mismatch();
    test_reset_midstream();
`ifdef SCRAMBLER_STATE_LOAD_EN
    test_load();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout got=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
